game_ctrl_seq: RTL and testbench

// - Parametrised top-level sequencer for the cellular-automaton game core.
// - Edge-detects user controls and sequences CLEAR/IDLE/SEED/RUN/PAUSE.
// - Drives board clear, LFSR seeding and run enable.
// - Generates the per-generation tick and counts generations; sits between the debounced button block and the board engine.

---
 rtl/game_ctrl_seq.sv | 113 +++++++++++
 tb/tb_game_ctrl_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_seq.sv
// Top-level sequencer for the cellular-automaton core: edge-detects controls and walks CLEAR/IDLE/SEED/RUN/PAUSE.
// Optional single-step in PAUSE is enabled by defining GAME_STEP_MODE_EN.
module game_ctrl_seq #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int RND_CYCLES = 64,
  parameter int CLR_CYCLES = 4,
  parameter int GEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             randomize,
  input  logic             stop,
  input  logic             clear,
`ifdef GAME_STEP_MODE_EN
  input  logic             step,
`endif
  output logic             clear_o,
  output logic             rnd_o,
  output logic             run_o,
  output logic             gen_tick_o,
  output logic [GEN_W-1:0] gen_count_o,
  output logic [2:0]       state_o
);
  localparam logic [2:0] S_CLEAR = 3'd0, S_IDLE = 3'd1, S_SEED = 3'd2,
                         S_RUN = 3'd3, S_PAUSE = 3'd4;
  localparam int CMAX = (RND_CYCLES > CLR_CYCLES) ? RND_CYCLES : CLR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int DW   = $clog2(TICK_DIV);

  logic [2:0]       state, nxt;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    div;
  logic [GEN_W-1:0] gen;
  logic [4:0]       btn, btn_q, rise;
  logic             armed, step_pend, step_i;
  logic             start_r, rnd_r, stop_r, clr_r, step_r;
  logic             tick_run, step_go;

`ifdef GAME_STEP_MODE_EN
  assign step_i = step;
`else
  assign step_i = 1'b0;
`endif

  // armed stays low for the first edge after reset so levels already high then give no rise
  assign btn  = {step_i, clear, stop, randomize, start};
  assign rise = btn & ~btn_q & {5{armed}};
  assign {step_r, clr_r, stop_r, rnd_r, start_r} = rise;

  assign tick_run = (state == S_RUN) && (div == DW'(TICK_DIV - 1));
  assign step_go  = step_r && (state == S_PAUSE) && (nxt == S_PAUSE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_CLEAR;
      btn_q     <= '0;
      armed     <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      state     <= nxt;
      btn_q     <= btn;
      armed     <= 1'b1;
      step_pend <= step_go;
    end
  end

  always_comb begin
    nxt = state;
    if (clr_r) nxt = S_CLEAR;
    else begin
      case (state)
        S_CLEAR: if (cnt == CW'(CLR_CYCLES - 1)) nxt = S_IDLE;
        S_IDLE:  if (rnd_r) nxt = S_SEED;
                 else if (start_r) nxt = S_RUN;
        S_SEED:  if (stop_r || cnt == CW'(RND_CYCLES - 1)) nxt = S_IDLE;
        S_RUN:   if (stop_r) nxt = S_PAUSE;
        S_PAUSE: if (stop_r) nxt = S_CLEAR;
                 else if (rnd_r) nxt = S_SEED;
                 else if (start_r) nxt = S_RUN;
        default: nxt = S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      div <= '0;
      gen <= '0;
    end else begin
      if (nxt != state || clr_r) cnt <= '0;
      else if (state == S_CLEAR || state == S_SEED) cnt <= cnt + CW'(1);

      // leaving RUN keeps div so a resume continues the current generation period
      if (state == S_IDLE && nxt == S_RUN) div <= '0;
      else if (state == S_RUN && nxt == S_RUN) div <= tick_run ? '0 : div + DW'(1);
      else if (step_go) div <= '0;

      if (nxt == S_CLEAR || (nxt == S_SEED && state != S_SEED)) gen <= '0;
      else if (tick_run || step_go) gen <= gen + GEN_W'(1);
    end
  end

  always_comb begin
    clear_o     = (state == S_CLEAR);
    rnd_o       = (state == S_SEED);
    run_o       = (state == S_RUN);
    gen_tick_o  = tick_run | step_pend;
    gen_count_o = gen;
    state_o     = state;
  end
endmodule

// File: tb/tb_game_ctrl_seq.sv
// Self-checking bench for game_ctrl_seq with TICK_DIV=4, RND_CYCLES=3, CLR_CYCLES=2, GEN_W=4.
module tb_game_ctrl_seq;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, randomize = 1'b0, stop = 1'b0, clear = 1'b0;
`ifdef GAME_STEP_MODE_EN
  logic step = 1'b0;
`endif
  logic clear_o, rnd_o, run_o, gen_tick_o;
  logic [3:0] gen_count_o;
  logic [2:0] state_o;

  int checks = 0, failures = 0;

  typedef struct {
    logic st, rn, sp, cl, stp;
    logic [2:0] est;
    logic etk;
    logic [3:0] egen;
  } vec_t;

  vec_t tab_a[$], tab_b[$];
  logic [11:0] sb[$];

  game_ctrl_seq #(.TICK_DIV(4), .RND_CYCLES(3), .CLR_CYCLES(2), .GEN_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .randomize(randomize), .stop(stop), .clear(clear),
`ifdef GAME_STEP_MODE_EN
    .step(step),
`endif
    .clear_o(clear_o), .rnd_o(rnd_o), .run_o(run_o), .gen_tick_o(gen_tick_o),
    .gen_count_o(gen_count_o), .state_o(state_o));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic st, logic rn, logic sp, logic cl, logic stp,
                              logic [2:0] est, logic etk, logic [3:0] egen);
    vec_t v;
    v.st = st; v.rn = rn; v.sp = sp; v.cl = cl; v.stp = stp;
    v.est = est; v.etk = etk; v.egen = egen;
    return v;
  endfunction

  // outputs packed as {state, clear_o, rnd_o, run_o, tick, gen}; strobes follow from the state code
  function automatic logic [11:0] expect_of(logic [2:0] est, logic etk, logic [3:0] egen);
    return {est, est == 3'd0, est == 3'd2, est == 3'd3, etk, egen};
  endfunction

  task automatic compare(string name);
    logic [11:0] exp_v, act;
    exp_v = sb.pop_front();
    act = {state_o, clear_o, rnd_o, run_o, gen_tick_o, gen_count_o};
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got st=%0d clr=%b rnd=%b run=%b tick=%b gen=%0d, want st=%0d clr=%b rnd=%b run=%b tick=%b gen=%0d",
               name, act[11:9], act[8], act[7], act[6], act[5], act[4:0],
               exp_v[11:9], exp_v[8], exp_v[7], exp_v[6], exp_v[5], exp_v[4:0]);
    end
  endtask

  task automatic apply(vec_t v, string name);
    start = v.st; randomize = v.rn; stop = v.sp; clear = v.cl;
`ifdef GAME_STEP_MODE_EN
    step = v.stp;
`endif
    sb.push_back(expect_of(v.est, v.etk, v.egen));
    @(posedge clk); #1;
    compare(name);
  endtask

  // start held high for n edges from IDLE: first edge is the rise
  task automatic run_loop(int n, string name);
    for (int k = 0; k < n; k++)
      apply(mk(1, 0, 0, 0, 0, 3'd3, (k % 4) == 3, 4'((k / 4) % 16)), name);
  endtask

  initial begin
    // power-up through seed
    tab_a.push_back(mk(0,0,0,0,0, 3'd0,0,0));
    tab_a.push_back(mk(0,0,0,0,0, 3'd1,0,0));
    tab_a.push_back(mk(0,0,0,0,0, 3'd1,0,0));
    tab_a.push_back(mk(0,1,0,0,0, 3'd2,0,0));
    tab_a.push_back(mk(0,1,0,0,0, 3'd2,0,0));
    tab_a.push_back(mk(0,1,0,0,0, 3'd2,0,0));
    tab_a.push_back(mk(0,1,0,0,0, 3'd1,0,0));
    tab_a.push_back(mk(0,1,0,0,0, 3'd1,0,0));
    tab_a.push_back(mk(0,0,0,0,0, 3'd1,0,0));
    // pause at div=1, resume, double stop, combos, aborts, clear in RUN
    tab_b.push_back(mk(0,0,1,0,0, 3'd4,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd4,0,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd3,0,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd3,0,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd3,1,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd3,0,1));
    tab_b.push_back(mk(0,0,1,0,0, 3'd4,0,1));
    tab_b.push_back(mk(0,0,0,0,0, 3'd4,0,1));
    tab_b.push_back(mk(0,0,1,0,0, 3'd0,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd0,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd1,0,0));
    tab_b.push_back(mk(1,1,0,0,0, 3'd2,0,0));
    tab_b.push_back(mk(1,1,0,0,0, 3'd2,0,0));
    tab_b.push_back(mk(1,1,0,0,0, 3'd2,0,0));
    tab_b.push_back(mk(1,1,0,0,0, 3'd1,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd1,0,0));
    tab_b.push_back(mk(0,1,0,0,0, 3'd2,0,0));
    tab_b.push_back(mk(0,0,1,0,0, 3'd1,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd1,0,0));
    tab_b.push_back(mk(0,1,0,0,0, 3'd2,0,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd2,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd2,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd1,0,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd3,0,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd3,0,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd3,0,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd3,1,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd3,0,1));
    tab_b.push_back(mk(1,0,0,1,0, 3'd0,0,0));
    tab_b.push_back(mk(0,0,0,1,0, 3'd0,0,0));
    tab_b.push_back(mk(0,0,0,1,0, 3'd1,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd1,0,0));
    tab_b.push_back(mk(1,0,0,0,0, 3'd3,0,0));
    tab_b.push_back(mk(1,1,0,0,0, 3'd3,0,0));
    tab_b.push_back(mk(0,0,1,0,0, 3'd4,0,0));
    tab_b.push_back(mk(0,1,0,0,0, 3'd2,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd2,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd2,0,0));
    tab_b.push_back(mk(0,0,0,0,0, 3'd1,0,0));
    tab_b.push_back(mk(0,1,0,0,0, 3'd2,0,0));

    repeat (2) @(posedge clk);
    #1;
    sb.push_back(expect_of(3'd0, 0, 0));
    compare("in_reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    sb.push_back(expect_of(3'd0, 0, 0));
    compare("post_release");
    // that edge consumed tab_a[0]'s slot; apply the rest
    for (int i = 1; i < tab_a.size(); i++) apply(tab_a[i], $sformatf("tab_a[%0d]", i));
    run_loop(66, "run_wrap");
    for (int i = 0; i < tab_b.size(); i++) apply(tab_b[i], $sformatf("tab_b[%0d]", i));

    // asynchronous reset mid-SEED, start held high across release
    #2 reset = 1'b1;
    start = 1'b1; randomize = 1'b0;
    #1;
    sb.push_back(expect_of(3'd0, 0, 0));
    compare("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    apply(mk(1,0,0,0,0, 3'd0,0,0), "rel_clear0");
    apply(mk(1,0,0,0,0, 3'd1,0,0), "rel_clear1");
    apply(mk(1,0,0,0,0, 3'd1,0,0), "held_start0");
    apply(mk(1,0,0,0,0, 3'd1,0,0), "held_start1");

`ifdef GAME_STEP_MODE_EN
    apply(mk(0,0,0,0,0, 3'd1,0,0), "step_idle");
    run_loop(21, "step_run");
    apply(mk(0,0,1,0,0, 3'd4,0,5), "step_pause");
    apply(mk(0,0,0,0,0, 3'd4,0,5), "step_pause_hold");
    apply(mk(0,0,0,0,1, 3'd4,1,6), "step_tick");
    for (int i = 0; i < 9; i++) apply(mk(0,0,0,0,1, 3'd4,0,6), "step_held");
    apply(mk(0,0,0,0,0, 3'd4,0,6), "step_release");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
